// File: rtl/ad9653_pkg.sv
// ad9653_pkg: shared FSM state type, AD9653 command widths and register addresses
package ad9653_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] REG_SPI_PORT_CFG = 13'h000;
    localparam logic [ADDR_W-1:0] REG_CHIP_ID      = 13'h001;
    localparam logic [ADDR_W-1:0] REG_POWER_MODES  = 13'h008;
    localparam logic [ADDR_W-1:0] REG_OUTPUT_MODE  = 13'h014;
    localparam logic [ADDR_W-1:0] REG_TRANSFER     = 13'h0FF;
    typedef enum logic [2:0] {
        IDLE, SETTLE, ISSUE, WAIT, GAP, FINISH, VCHK_ISSUE, VCHK_WAIT
    } state_t;
endpackage

// File: rtl/ad9653_config_sequencer_if.sv
// ad9653_config_sequencer_if: command/completion bundle between sequencer and SPI master
interface ad9653_config_sequencer_if;
    import ad9653_pkg::*;
    logic              spi_start;
    logic              spi_rw;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_done;
    logic [DATA_W-1:0] spi_rdata;
    modport master (output spi_start, spi_rw, spi_addr, spi_wdata, input spi_done, spi_rdata);
    modport slave  (input spi_start, spi_rw, spi_addr, spi_wdata, output spi_done, spi_rdata);
endinterface

// File: rtl/ad9653_config_sequencer_delay.sv
// seq_delay_counter: loadable down-counter shared by the GAP and timeout waits
module seq_delay_counter #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (count && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/ad9653_config_sequencer.sv
// ad9653_config_sequencer: walks an external register LUT and issues one SPI write/read per entry.
// Define AD9653_READBACK_VERIFY_EN to follow every write with a verifying readback.
module ad9653_config_sequencer
    import ad9653_pkg::*;
#(
    parameter int NUM_ENTRIES    = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [4:0]            err_index,
    output logic [4:0]            lut_index,
    input  logic [ADDR_W-1:0]     lut_address,
    input  logic [DATA_W-1:0]     lut_data,
    input  logic                  lut_rw,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    ad9653_config_sequencer_if.master spi
);
`ifdef AD9653_READBACK_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif
    localparam int CW = $clog2((GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES) + 1);
    localparam logic [4:0] LAST = 5'(NUM_ENTRIES - 1);
    state_t state, state_n;
    logic abort_q, verify_q, dly_load, dly_count, dly_expired;
    logic [CW-1:0] dly_value;
    logic in_wait, timed_out, gap_end, seq_end;
    assign in_wait   = state == WAIT || state == VCHK_WAIT;
    assign timed_out = in_wait && !spi.spi_done && dly_expired;
    assign gap_end   = state == GAP && dly_expired;
    assign seq_end   = lut_index == LAST || abort_q;
    assign busy = state != IDLE;
    assign done = state == FINISH;
    assign spi.spi_start = state == ISSUE || state == VCHK_ISSUE;
    seq_delay_counter #(.W(CW)) u_delay (
        .clk(clk), .reset_n(reset_n), .load(dly_load), .count(dly_count),
        .value(dly_value), .expired(dly_expired)
    );
    always_comb begin
        state_n   = state;
        dly_load  = 1'b0;
        dly_count = 1'b0;
        dly_value = CW'(GAP_CYCLES - 1);
        case (state)
            IDLE:   state_n = start ? SETTLE : IDLE;
            SETTLE: state_n = ISSUE;
            ISSUE, VCHK_ISSUE: begin
                state_n   = state == ISSUE ? WAIT : VCHK_WAIT;
                dly_load  = 1'b1;
                dly_value = CW'(TIMEOUT_CYCLES - 1);
            end
            WAIT, VCHK_WAIT: begin
                state_n   = spi.spi_done ? GAP : dly_expired ? FINISH : state;
                dly_load  = spi.spi_done;
                dly_count = !spi.spi_done;
            end
            GAP: begin
                state_n   = !dly_expired ? GAP : verify_q ? VCHK_ISSUE : seq_end ? FINISH : SETTLE;
                dly_count = !dly_expired;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            abort_q       <= 1'b0;
            verify_q      <= 1'b0;
            error         <= 1'b0;
            err_index     <= '0;
            lut_index     <= '0;
            rdata         <= '0;
            rdata_valid   <= 1'b0;
            spi.spi_rw    <= 1'b0;
            spi.spi_addr  <= '0;
            spi.spi_wdata <= '0;
        end else begin
            state       <= state_n;
            rdata_valid <= 1'b0;
            if (busy && abort) abort_q <= 1'b1;
            if (state == IDLE && start) begin
                error     <= 1'b0;
                lut_index <= '0;
            end
            if (state == SETTLE) begin
                spi.spi_addr  <= lut_address;
                spi.spi_wdata <= lut_data;
                spi.spi_rw    <= lut_rw;
            end
            if (state == WAIT && spi.spi_done) begin
                if (spi.spi_rw) rdata <= spi.spi_rdata;
                rdata_valid <= spi.spi_rw;
                verify_q    <= VERIFY_EN && !spi.spi_rw;
            end
            // Only the first failure is recorded; a readback mismatch lets the walk continue.
            if (!error && (timed_out || (state == VCHK_WAIT && spi.spi_done && spi.spi_rdata != spi.spi_wdata))) begin
                error     <= 1'b1;
                err_index <= lut_index;
            end
            if (gap_end) begin
                if (verify_q) begin
                    verify_q   <= 1'b0;
                    spi.spi_rw <= 1'b1;
                end else if (!seq_end) lut_index <= lut_index + 5'd1;
            end
            if (state == FINISH) abort_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ad9653_config_sequencer.sv
// tb_ad9653_config_sequencer: directed checks of the LUT walk, readback capture, timeout, abort and reset.
module tb_ad9653_config_sequencer;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy, done, error, rdata_valid, lut_rw;
    logic [4:0] err_index, lut_index, sidx;
    logic [12:0] lut_address, last_addr, first_addr;
    logic [7:0] lut_data, rdata;
    int checks = 0, errors = 0;
    int cyc = 0, n_start = 0, n_prim = 0, n_rv = 0, n_done = 0, n_sd = 0;
    int addr_err = 0, overlap = 0, last_sd = 0, done_cyc = 0, hang_idx = -1, mcnt = 0;
    bit outst = 1'b0, corrupt = 1'b0;
    ad9653_config_sequencer_if spi();
    ad9653_config_sequencer #(.NUM_ENTRIES(16), .GAP_CYCLES(8), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .error(error), .err_index(err_index), .lut_index(lut_index), .lut_address(lut_address),
        .lut_data(lut_data), .lut_rw(lut_rw), .rdata(rdata), .rdata_valid(rdata_valid), .spi(spi.master)
    );
    always #5 clk = ~clk;
    // LUT: entry i writes i+1 to address 8+i; entry 2 is a read
    assign lut_address = 13'h008 + 13'(lut_index);
    assign lut_data    = 8'(lut_index) + 8'd1;
    assign lut_rw      = lut_index == 5'd2;
    // SPI master model: completes 20 cycles after spi_start unless the entry is set to hang
    assign sidx          = 5'(spi.spi_addr - 13'h008);
    assign spi.spi_done  = mcnt == 1;
    assign spi.spi_rdata = sidx == 5'd2 ? 8'h18 : (corrupt && sidx == 5'd6) ? 8'h00 : 8'(sidx) + 8'd1;
    always @(posedge clk) begin
        if (spi.spi_start && int'(sidx) != hang_idx) mcnt <= 21;
        else if (mcnt != 0) mcnt <= mcnt - 1;
    end
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) outst = 1'b0;
        if (spi.spi_start) begin
            if (outst) overlap++;
            outst = 1'b1;
            if (n_start == 0) first_addr = spi.spi_addr;
            if (n_start != 0 && spi.spi_addr == last_addr) ;
            else if (spi.spi_addr == 13'h008 + 13'(n_prim)) n_prim++;
            else addr_err++;
            last_addr = spi.spi_addr;
            n_start++;
        end
        if (spi.spi_done) begin
            outst = 1'b0;
            last_sd = cyc;
            n_sd++;
        end
        if (rdata_valid) n_rv++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic clr();
        n_start = 0; n_prim = 0; n_rv = 0; n_done = 0; n_sd = 0; addr_err = 0; overlap = 0;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask
    task automatic wait_done(input int lim, input string tag);
        int k = 0;
        while (!done && k < lim) begin
            tick(1);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask
    task automatic wait_starts(input int n, input int lim, input string tag);
        int k = 0;
        while (n_start < n && k < lim) begin
            tick(1);
            k++;
        end
        check(tag, 32'(n_start >= n), 32'd1);
    endtask
    initial begin
        tick(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_spi_start", 32'(spi.spi_start), 0);
        check("rst_lut_index", 32'(lut_index), 0);
        reset_n = 1'b1;
        tick(2);
        // full walk, with a stray start while busy
        clr();
        pulse_start();
        tick(100);
        pulse_start();
        wait_done(2000, "run_done_seen");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("run_idle_after_finish_start", 32'(busy), 0);
        check("run_starts", 32'(n_start), 16);
        check("run_addr_order", 32'(addr_err), 0);
        check("run_error", 32'(error), 0);
        check("run_done_pulses", 32'(n_done), 1);
        check("run_gap_to_done", 32'(done_cyc - last_sd), 9);
        check("run_rdata", 32'(rdata), 32'h18);
        check("run_rdata_valid_pulses", 32'(n_rv), 1);
        check("run_overlap", 32'(overlap), 0);
        // timeout at entry 5
        clr();
        hang_idx = 5;
        pulse_start();
        wait_done(6000, "to_done_seen");
        tick(1);
        check("to_error", 32'(error), 1);
        check("to_err_index", 32'(err_index), 5);
        check("to_starts", 32'(n_start), 6);
        check("to_busy", 32'(busy), 0);
        tick(5);
        check("to_error_sticky", 32'(error), 1);
        hang_idx = -1;
        // abort during entry 3
        clr();
        pulse_start();
        check("abort_error_cleared", 32'(error), 0);
        wait_starts(4, 2000, "abort_reach_idx3");
        tick(5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_done(500, "abort_done_seen");
        tick(1);
        check("abort_starts", 32'(n_start), 4);
        check("abort_completed", 32'(n_sd), 4);
        check("abort_error", 32'(error), 0);
        check("abort_done_pulses", 32'(n_done), 1);
        // reset during entry 7
        clr();
        pulse_start();
        wait_starts(8, 2000, "rst_reach_idx7");
        tick(5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_lut_index", 32'(lut_index), 0);
        check("mid_rst_err_index", 32'(err_index), 0);
        check("mid_rst_rdata", 32'(rdata), 0);
        check("mid_rst_spi_addr", 32'(spi.spi_addr), 0);
        check("mid_rst_spi_wdata", 32'(spi.spi_wdata), 0);
        check("mid_rst_spi_rw", 32'(spi.spi_rw), 0);
        tick(3);
        reset_n = 1'b1;
        tick(1);
        clr();
        tick(40);
        check("post_rst_no_start", 32'(n_start), 0);
        pulse_start();
        wait_starts(1, 50, "post_rst_first_start");
        check("post_rst_first_addr", 32'(first_addr), 32'h008);
        wait_done(2000, "post_rst_done_seen");
        tick(1);
        check("post_rst_starts", 32'(n_start), 16);
`ifdef AD9653_READBACK_VERIFY_EN
        clr();
        corrupt = 1'b1;
        pulse_start();
        wait_done(4000, "vchk_done_seen");
        tick(1);
        check("vchk_error", 32'(error), 1);
        check("vchk_err_index", 32'(err_index), 6);
        check("vchk_starts", 32'(n_start), 31);
        check("vchk_primaries", 32'(n_prim), 16);
        corrupt = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
